cordic_phase_gen: RTL
=====================

CORDIC_PHASE_GEN -- requirements
Module: cordic_phase_gen

Interface
REQ-001 SHALL have parameter XY_BITS, default 12, the width of the x_i/y_i sample outputs.
REQ-002 SHALL have parameter PH_BITS, default 32, the width of the phase and frequency words.
REQ-003 SHALL have parameter AMPLITUDE, default 1243, the x_i value driven while valid (about 0.607 of full scale, pre-compensating CORDIC gain).
REQ-004 SHALL have port clk_in  in  1  the single clock; all logic rising-edge.
REQ-005 SHALL have port RST  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port start  in  1  single-cycle request to begin a burst.
REQ-007 SHALL have port stop  in  1  single-cycle abort request.
REQ-008 SHALL have port fcw_in  in  PH_BITS  initial frequency control word, unsigned.
REQ-009 SHALL have port step_in  in  PH_BITS  per-sample fcw increment, two's complement.
REQ-010 SHALL have port count_in  in  16  samples per burst; 0 means continuous.
REQ-011 SHALL have port x_i  out  XY_BITS  CORDIC x operand.
REQ-012 SHALL have port y_i  out  XY_BITS  CORDIC y operand.
REQ-013 SHALL have port phase_in  out  PH_BITS  CORDIC phase operand.
REQ-014 SHALL have port valid_in  out  1  sample strobe to CORDIC.
REQ-015 SHALL have port busy  out  1  high in RUN.
REQ-016 SHALL have port done  out  1  one-cycle pulse on normal burst completion.

Function
REQ-017 SHALL implement states IDLE, RUN and DONE, with all outputs registered.
REQ-018 SHALL, in IDLE with start=1 and stop=0, latch fcw_in, step_in and count_in, clear the phase accumulator and sample counter, and enter RUN.
REQ-019 SHALL, in RUN, per cycle: assert valid_in=1; phase_in=acc; update acc+=fcw_cur and fcw_cur+=step, both mod 2^PH_BITS, with no saturation.
REQ-020 SHALL produce phase_in sequence 0, F, 2F+S, 3F+3S, ... for fcw F and step S, with the first valid_in in the cycle after start is sampled.
REQ-021 SHALL drive x_i=AMPLITUDE and y_i=0 when valid_in=1, and x_i=y_i=0 otherwise.
REQ-022 SHALL, with count N>0, emit exactly N valid samples, then enter DONE for one cycle (done=1, valid_in=0), then IDLE.
REQ-023 SHALL, with count 0, run until stop.
REQ-024 SHALL, on stop in RUN, emit no further valid_in from the next cycle, return to IDLE, and never assert done.
REQ-025 SHALL, if stop and the Nth sample coincide, emit the Nth sample and take the stop path (no done).
REQ-026 SHALL ignore start while in RUN or DONE.
REQ-027 SHALL, on start and stop together in IDLE, stay in IDLE.
REQ-028 SHALL drive busy=1 exactly in RUN.

Reset
REQ-029 SHALL, on RST=1, immediately force IDLE and drive x_i, y_i, phase_in, valid_in, busy and done to 0, clearing acc, fcw_cur and the counter.
REQ-030 SHALL, on reset mid-burst, discard the burst; a new start is required after RST falls.

Configuration
REQ-031 SHALL, with PHASE_DITHER_EN defined, add a 16-bit maximal-length LFSR (seed 16'hACE1, advancing each valid sample) into the low 4 bits of phase_in, wrapping; acc itself is undithered.
REQ-032 SHALL, without PHASE_DITHER_EN, contain no LFSR logic, with phase_in=acc exactly.

Structure
REQ-033 SHALL place the state enum, the LFSR seed/taps and the default AMPLITUDE in shared package cordic_pkg, also used by the CORDIC stage.
REQ-034 SHALL implement the dither source as sub-module phase_lfsr, instantiated only under PHASE_DITHER_EN.

Verification
REQ-035 SHALL cover: fcw=32'h1000_0000, step=0, count=4 -> phase_in 0, 10000000, 20000000, 30000000; done pulses one cycle after the 4th sample.
REQ-036 SHALL cover: fcw=100, step=10, count=3 -> phase_in 0, 100, 210; busy high exactly 3 cycles.
REQ-037 SHALL cover: fcw=32'hC000_0000, count=0, stop after 5 samples -> phase_in wraps 0, C0000000, 80000000, 40000000, 0; no done.
REQ-038 SHALL cover: RST asserted at the 2nd sample of count=10 -> all outputs 0 asynchronously; restart yields phase_in=0 first.
REQ-039 SHALL cover: start during RUN, plus start and stop together in IDLE -> both ignored, with no change to sequence or state.
REQ-040 SHALL cover, with PHASE_DITHER_EN: fcw=0, count=4 -> phase_in upper 28 bits 0 and low 4 bits matching the phase_lfsr reference sequence.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: phase-generator state encoding, default drive
// amplitude and the dither LFSR seed/taps.
package cordic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gen_state_t;

    // About 0.607 of 12-bit full scale, cancelling the CORDIC gain of ~1.647.
    localparam int unsigned DEFAULT_AMPLITUDE = 1243;

    // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/phase_lfsr.sv
// 16-bit maximal-length LFSR used as the phase dither source.
// Holds the seed while loaded and steps once per advance.
module phase_lfsr
    import cordic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    output logic [15:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= LFSR_SEED;
        end else if (load) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/cordic_phase_gen.sv
// Burst phase-ramp generator feeding a CORDIC rotator with registered operands.
// Optional low-bit phase dither is enabled by defining PHASE_DITHER_EN.
module cordic_phase_gen
    import cordic_pkg::*;
#(
    parameter int unsigned XY_BITS   = 12,
    parameter int unsigned PH_BITS   = 32,
    parameter int unsigned AMPLITUDE = DEFAULT_AMPLITUDE
) (
    input  logic               clk_in,
    input  logic               RST,
    input  logic               start,
    input  logic               stop,
    input  logic [PH_BITS-1:0] fcw_in,
    input  logic [PH_BITS-1:0] step_in,
    input  logic [15:0]        count_in,
    output logic [XY_BITS-1:0] x_i,
    output logic [XY_BITS-1:0] y_i,
    output logic [PH_BITS-1:0] phase_in,
    output logic               valid_in,
    output logic               busy,
    output logic               done
);

    localparam logic [XY_BITS-1:0] AMP = XY_BITS'(AMPLITUDE);

    gen_state_t         state;
    gen_state_t         state_nxt;
    logic [PH_BITS-1:0] acc;
    logic [PH_BITS-1:0] acc_nxt;
    logic [PH_BITS-1:0] fcw_cur;
    logic [PH_BITS-1:0] fcw_nxt;
    logic [PH_BITS-1:0] step_q;
    logic [PH_BITS-1:0] step_nxt;
    logic [15:0]        count_q;
    logic [15:0]        count_nxt;
    logic [15:0]        cnt;
    logic [15:0]        cnt_nxt;
    logic [PH_BITS-1:0] phase_raw;
    logic [PH_BITS-1:0] phase_out;
    logic               emit;
    logic               fire_done;

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            acc     <= '0;
            fcw_cur <= '0;
            step_q  <= '0;
            count_q <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            fcw_cur <= fcw_nxt;
            step_q  <= step_nxt;
            count_q <= count_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // emit marks the edge that registers a valid sample; cnt counts samples
    // already presented, so cnt == count_q means the last one is on the outputs.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        fcw_nxt   = fcw_cur;
        step_nxt  = step_q;
        count_nxt = count_q;
        cnt_nxt   = cnt;
        phase_raw = '0;
        emit      = 1'b0;
        fire_done = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                    emit      = 1'b1;
                    phase_raw = '0;
                    acc_nxt   = fcw_in;
                    fcw_nxt   = fcw_in + step_in;
                    step_nxt  = step_in;
                    count_nxt = count_in;
                    cnt_nxt   = 16'd1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if ((count_q != '0) && (cnt == count_q)) begin
                    state_nxt = DONE;
                    fire_done = 1'b1;
                end else begin
                    emit      = 1'b1;
                    phase_raw = acc;
                    acc_nxt   = acc + fcw_cur;
                    fcw_nxt   = fcw_cur + step_q;
                    cnt_nxt   = cnt + 16'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef PHASE_DITHER_EN
    logic [15:0] dither;

    phase_lfsr u_lfsr (
        .clk     (clk_in),
        .rst     (RST),
        .load    (!emit),
        .advance (emit),
        .value   (dither)
    );

    // Dither wraps inside the low nibble so the upper phase bits stay exact.
    always_comb begin
        phase_out = {phase_raw[PH_BITS-1:4], phase_raw[3:0] + dither[3:0]};
    end
`else
    always_comb begin
        phase_out = phase_raw;
    end
`endif

    always_ff @(posedge clk_in or posedge RST) begin
        if (RST) begin
            x_i      <= '0;
            y_i      <= '0;
            phase_in <= '0;
            valid_in <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            x_i      <= emit ? AMP : '0;
            y_i      <= '0;
            phase_in <= emit ? phase_out : '0;
            valid_in <= emit;
            busy     <= (state_nxt == RUN);
            done     <= fire_done;
        end
    end

endmodule
